// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and helpers for the 7-segment display scheduler.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents:
//   state_t   - scheduler modes (live score, message, game-over score / high score)
//   BLANK_ALL - mask that darkens every digit
//   lz_blank  - leading-zero blank mask for a 4-digit BCD word
package seg_sched_pkg;

    typedef enum logic [1:0] {
        SCORE   = 2'd0,
        MSG     = 2'd1,
        OVER_SC = 2'd2,
        OVER_HI = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_ALL = 4'b1111;

    // Blank zero digits from the most significant end until the first
    // non-zero nibble. Digit 0 always lights so a zero value still shows "0".
    // Non-BCD nibbles are non-zero, so they stop the blanking like any digit.
    function automatic logic [3:0] lz_blank(input logic [15:0] bcd);
        logic [3:0] m;
        m[3] = (bcd[15:12] == 4'd0);
        m[2] = m[3] & (bcd[11:8] == 4'd0);
        m[1] = m[2] & (bcd[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_scan_timer.sv
// Digit scan timer: free-running divider that steps the active digit index.
// Latency: scan_tick/scan_idx update one cycle after the divider terminal count.
// Backpressure: none; runs continuously out of reset.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   scan_tick out  one-cycle pulse each time scan_idx advances
//   scan_idx  out  active digit 0..3 (0 = units), wraps 3 -> 0
module seg_scan_timer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       scan_tick,
    output logic [1:0] scan_idx
);

    localparam int               DIV_W    = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            scan_tick <= 1'b0;
            scan_idx  <= 2'd0;
        end else if (r_div == DIV_LAST) begin
            r_div     <= '0;
            scan_tick <= 1'b1;
            scan_idx  <= scan_idx + 2'd1;
        end else begin
            r_div     <= r_div + DIV_W'(1);
            scan_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Display scheduler: picks live score, a timed message, or game-over score/high-score for a 4-digit display.
// Latency: all outputs registered; an input change reaches disp_* one cycle later, msg_ack in the accepting cycle's next edge.
// Backpressure: msg_req is a level held until msg_ack; requests are refused while game_over is high and stay pending.
//
// Optional build macro SEG_SCHED_BLINK_EN: blinks the whole display in the
// game-over score phase (dark on odd BLINK_PERIOD halves).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   score_bcd    in   live score, 4 BCD digits, [3:0] = units
//   game_over    in   level, high while the game is over
//   msg_req      in   message request level, held until msg_ack
//   msg_bcd      in   message digits, captured in the accepting cycle
//   msg_ack      out  one-cycle pulse, message accepted
//   disp_bcd     out  digits to display
//   disp_blank   out  per-digit blank mask (1 = dark)
//   scan_idx     out  active digit 0..3
//   scan_tick    out  one-cycle pulse when scan_idx advances
//   hiscore_bcd  out  high score
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int MSG_HOLD     = 100000000,
    parameter int ALT_PERIOD   = 150000000
`ifdef SEG_SCHED_BLINK_EN
    ,
    parameter int BLINK_PERIOD = 25000000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score_bcd,
    input  logic        game_over,
    input  logic        msg_req,
    input  logic [15:0] msg_bcd,
    output logic        msg_ack,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_blank,
    output logic [1:0]  scan_idx,
    output logic        scan_tick,
    output logic [15:0] hiscore_bcd
);

    localparam int                HOLD_W    = $clog2(MSG_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MSG_HOLD - 1);
    localparam int                ALT_W     = $clog2(ALT_PERIOD + 1);
    localparam logic [ALT_W-1:0]  ALT_LAST  = ALT_W'(ALT_PERIOD - 1);

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .scan_tick (scan_tick),
        .scan_idx  (scan_idx)
    );

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [ALT_W-1:0]    r_alt;
    logic [15:0]         r_msg;
    logic                r_go_d;
    logic                r_msg_armed;

    state_t              w_nxt_state;
    logic                w_go_rise;
    logic                w_accept;
    logic [15:0]         w_nxt_disp;
    logic [3:0]          w_nxt_blank;
    logic [15:0]         w_nxt_hiscore;

    assign w_go_rise = game_over & ~r_go_d;
    // Only a fresh request is taken: r_msg_armed drops on ack and re-arms
    // once msg_req has been seen low, so a held request is not replayed.
    assign w_accept  = (r_state == SCORE) & msg_req & r_msg_armed & ~game_over;

    assign w_nxt_hiscore = (w_go_rise && (score_bcd > hiscore_bcd)) ? score_bcd : hiscore_bcd;

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            SCORE: begin
                if (w_go_rise)     w_nxt_state = OVER_SC;
                else if (w_accept) w_nxt_state = MSG;
            end
            MSG: begin
                if (game_over)               w_nxt_state = OVER_SC;
                else if (r_hold == HOLD_LAST) w_nxt_state = SCORE;
            end
            OVER_SC: begin
                if (!game_over)             w_nxt_state = SCORE;
                else if (r_alt == ALT_LAST) w_nxt_state = OVER_HI;
            end
            OVER_HI: begin
                if (!game_over)             w_nxt_state = SCORE;
                else if (r_alt == ALT_LAST) w_nxt_state = OVER_SC;
            end
            default: w_nxt_state = SCORE;
        endcase
    end

    // Display content follows the state being entered so disp_* changes on
    // the same edge as the state register.
    always_comb begin
        w_nxt_disp = score_bcd;
        case (w_nxt_state)
            MSG:     w_nxt_disp = w_accept ? msg_bcd : r_msg;
            OVER_HI: w_nxt_disp = hiscore_bcd;
            default: w_nxt_disp = score_bcd;
        endcase
    end

`ifdef SEG_SCHED_BLINK_EN
    localparam int                 BLINK_W    = $clog2(BLINK_PERIOD + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_odd;
    logic [BLINK_W-1:0] w_nxt_blink_cnt;
    logic               w_nxt_blink_odd;

    // Blink phase restarts (lit) every time OVER_SC is entered.
    always_comb begin
        w_nxt_blink_cnt = '0;
        w_nxt_blink_odd = 1'b0;
        if (r_state == OVER_SC && w_nxt_state == OVER_SC) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_nxt_blink_cnt = '0;
                w_nxt_blink_odd = ~r_blink_odd;
            end else begin
                w_nxt_blink_cnt = r_blink_cnt + BLINK_W'(1);
                w_nxt_blink_odd = r_blink_odd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_odd <= 1'b0;
        end else begin
            r_blink_cnt <= w_nxt_blink_cnt;
            r_blink_odd <= w_nxt_blink_odd;
        end
    end

    assign w_nxt_blank = (w_nxt_state == OVER_SC && w_nxt_blink_odd) ? BLANK_ALL : lz_blank(w_nxt_disp);
`else
    assign w_nxt_blank = lz_blank(w_nxt_disp);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCORE;
            r_hold      <= '0;
            r_alt       <= '0;
            r_msg       <= '0;
            r_go_d      <= 1'b0;
            r_msg_armed <= 1'b1;
            msg_ack     <= 1'b0;
            disp_bcd    <= '0;
            disp_blank  <= 4'b1110;
            hiscore_bcd <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_go_d      <= game_over;
            msg_ack     <= w_accept;
            disp_bcd    <= w_nxt_disp;
            disp_blank  <= w_nxt_blank;
            hiscore_bcd <= w_nxt_hiscore;

            if (w_accept) r_msg <= msg_bcd;

            if (w_accept)     r_msg_armed <= 1'b0;
            else if (!msg_req) r_msg_armed <= 1'b1;

            // Counters restart on every state change, so neither can wrap.
            if (w_nxt_state != r_state || r_state != MSG) r_hold <= '0;
            else                                          r_hold <= r_hold + HOLD_W'(1);

            if (w_nxt_state != r_state || (r_state != OVER_SC && r_state != OVER_HI)) r_alt <= '0;
            else                                                                      r_alt <= r_alt + ALT_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Testbench for seg_display_scheduler: directed scenarios then random traffic against a timeline model.
// Latency: model predicts registered outputs one edge after the inputs it consumes.
// Backpressure: n/a.
module tb_seg_display_scheduler;

    localparam int SCAN_DIV   = 4;
    localparam int MSG_HOLD   = 10;
    localparam int ALT_PERIOD = 8;
`ifdef SEG_SCHED_BLINK_EN
    localparam int BLINK_PERIOD = 2;
`endif

    localparam int M_SCORE = 0;
    localparam int M_MSG   = 1;
    localparam int M_OVER  = 2;

    logic        clk;
    logic        reset;
    logic [15:0] score_bcd;
    logic        game_over;
    logic        msg_req;
    logic [15:0] msg_bcd;
    logic        msg_ack;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_blank;
    logic [1:0]  scan_idx;
    logic        scan_tick;
    logic [15:0] hiscore_bcd;

    seg_display_scheduler #(
        .SCAN_DIV     (SCAN_DIV),
        .MSG_HOLD     (MSG_HOLD),
        .ALT_PERIOD   (ALT_PERIOD)
`ifdef SEG_SCHED_BLINK_EN
        ,
        .BLINK_PERIOD (BLINK_PERIOD)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .score_bcd   (score_bcd),
        .game_over   (game_over),
        .msg_req     (msg_req),
        .msg_bcd     (msg_bcd),
        .msg_ack     (msg_ack),
        .disp_bcd    (disp_bcd),
        .disp_blank  (disp_blank),
        .scan_idx    (scan_idx),
        .scan_tick   (scan_tick),
        .hiscore_bcd (hiscore_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Timeline model: mode plus the cycle it was entered; timed behaviour
    // is derived from elapsed cycles with plain arithmetic.
    int          cyc;
    int          mode;
    int          t_enter;
    logic [15:0] m_msg;
    logic [15:0] m_hi;
    logic        go_prev;
    logic        armed;
    logic [15:0] e_disp;
    logic [3:0]  e_blank;
    logic        e_ack;
    logic [1:0]  e_idx;
    logic        e_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_blank(input logic [15:0] v);
        logic [3:0] m;
        m = 4'b0000;
        for (int k = 3; k >= 1; k--) begin
            if (v[k*4 +: 4] != 4'd0) break;
            m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        cyc = 0; mode = M_SCORE; t_enter = 0;
        m_msg = 16'h0; m_hi = 16'h0; go_prev = 1'b0; armed = 1'b1;
        e_disp = 16'h0; e_blank = 4'b1110; e_ack = 1'b0; e_idx = 2'd0; e_tick = 1'b0;
    endtask

    task automatic model_edge(input logic go, input logic req, input logic [15:0] sc, input logic [15:0] mb);
        logic rise;
        int   el;
        cyc++;
        rise  = go && !go_prev;
        e_ack = 1'b0;
        case (mode)
            M_SCORE: begin
                if (rise) begin
                    mode = M_OVER; t_enter = cyc;
                end else if (req && armed && !go) begin
                    mode = M_MSG; t_enter = cyc; m_msg = mb; e_ack = 1'b1;
                end
            end
            M_MSG: begin
                if (go) begin
                    mode = M_OVER; t_enter = cyc;
                end else if (cyc - t_enter == MSG_HOLD) begin
                    mode = M_SCORE;
                end
            end
            default: if (!go) mode = M_SCORE;
        endcase
        if (rise && sc > m_hi) m_hi = sc;
        if (e_ack) armed = 1'b0;
        else if (!req) armed = 1'b1;
        go_prev = go;

        el = cyc - t_enter;
        case (mode)
            M_MSG:   e_disp = m_msg;
            M_OVER:  e_disp = (((el / ALT_PERIOD) % 2) == 1) ? m_hi : sc;
            default: e_disp = sc;
        endcase
        e_blank = ref_blank(e_disp);
`ifdef SEG_SCHED_BLINK_EN
        if (mode == M_OVER && ((el / ALT_PERIOD) % 2) == 0 &&
            (((el % (2 * ALT_PERIOD)) / BLINK_PERIOD) % 2) == 1)
            e_blank = 4'b1111;
`endif
        e_idx  = 2'((cyc / SCAN_DIV) % 4);
        e_tick = (cyc % SCAN_DIV) == 0;
    endtask

    task automatic step(input logic go, input logic req, input logic [15:0] sc, input logic [15:0] mb);
        game_over = go; msg_req = req; score_bcd = sc; msg_bcd = mb;
        @(posedge clk);
        model_edge(go, req, sc, mb);
        #1;
        chk("disp_bcd",    32'(disp_bcd),    32'(e_disp));
        chk("disp_blank",  32'(disp_blank),  32'(e_blank));
        chk("msg_ack",     32'(msg_ack),     32'(e_ack));
        chk("scan_idx",    32'(scan_idx),    32'(e_idx));
        chk("scan_tick",   32'(scan_tick),   32'(e_tick));
        chk("hiscore_bcd", 32'(hiscore_bcd), 32'(m_hi));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_disp"},  32'(disp_bcd),    32'h0);
        chk({tag, "_blank"}, 32'(disp_blank),  32'b1110);
        chk({tag, "_ack"},   32'(msg_ack),     32'h0);
        chk({tag, "_idx"},   32'(scan_idx),    32'h0);
        chk({tag, "_tick"},  32'(scan_tick),   32'h0);
        chk({tag, "_hi"},    32'(hiscore_bcd), 32'h0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        logic        r_go;
        logic        r_req;
        logic [15:0] r_sc;

        reset = 1'b1; game_over = 1'b0; msg_req = 1'b0; score_bcd = 16'h0; msg_bcd = 16'h0;
        #2 reset = 1'b0;
        #1 chk_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        model_reset();

        // Idle: scan timing and default blanking.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0000, 16'h0);

        // Live score with two blanked leading digits, then a non-BCD digit.
        repeat (3) step(1'b0, 1'b0, 16'h0050, 16'h0);
        repeat (2) step(1'b0, 1'b0, 16'h0A07, 16'h0);

        // Message held high across and beyond its display window.
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 16'h0050, 16'h1234);
        repeat (2) step(1'b0, 1'b0, 16'h0050, 16'h0);

        // Game over: high score update and score/high-score alternation.
        repeat (3) step(1'b1, 1'b0, 16'h0099, 16'h0);
        repeat (2) step(1'b0, 1'b0, 16'h0099, 16'h0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0120, 16'h0);
        repeat (2) step(1'b0, 1'b0, 16'h0120, 16'h0);

        // Lower score at game over must leave the high score alone.
        repeat (3) step(1'b1, 1'b0, 16'h0042, 16'h0);
        repeat (2) step(1'b0, 1'b0, 16'h0042, 16'h0);

        // Request and game over rising together: ack only after game over ends.
        repeat (4) step(1'b1, 1'b1, 16'h0007, 16'h4321);
        repeat (4) step(1'b0, 1'b1, 16'h0007, 16'h4321);
        repeat (2) step(1'b0, 1'b0, 16'h0007, 16'h0);

        // Game over in the middle of a message cuts it short.
        repeat (3) step(1'b0, 1'b1, 16'h0003, 16'h0808);
        repeat (3) step(1'b1, 1'b1, 16'h0003, 16'h0808);
        repeat (2) step(1'b0, 1'b0, 16'h0003, 16'h0);

        // Game-over score phase (blinks in the blink build), then async reset.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 16'h0005, 16'h5555);
        reset = 1'b0;
        #1 chk_reset_values("midreset");
        @(negedge clk);
        game_over = 1'b0;
        reset = 1'b1;
        model_reset();
        // Request still high after reset counts as a new one.
        repeat (3) step(1'b0, 1'b1, 16'h0011, 16'h2468);
        repeat (12) step(1'b0, 1'b0, 16'h0011, 16'h0);

        // Random traffic.
        r_go = 1'b0; r_req = 1'b0; r_sc = 16'h0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 11) == 0) r_go = ~r_go;
            if ($urandom_range(0, 3) == 0)  r_req = ~r_req;
            if ($urandom_range(0, 2) == 0)  r_sc = ($urandom_range(0, 15) == 0) ? 16'($urandom) : rand_bcd();
            step(r_go, r_req, r_sc, rand_bcd());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
